// File: rtl/wb2axil_pkg.sv
// rtl/wb2axil_pkg.sv - shared types and constants for the WB-to-AXI-lite bridge
package wb2axil_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        BRESP = 3'd2,
        READ  = 3'd3,
        RRESP = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXPROT_DEFAULT = 3'b000;

    // SLVERR and DECERR map to a WB error; OKAY and EXOKAY map to an ack.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic is_err;
        is_err = 1'b0;
        case (resp)
            RESP_OKAY, RESP_EXOKAY:   is_err = 1'b0;
            RESP_SLVERR, RESP_DECERR: is_err = 1'b1;
            default:                  is_err = 1'b0;
        endcase
        return is_err;
    endfunction

endpackage

// File: rtl/wbsp_to_axil.sv
// rtl/wbsp_to_axil.sv - pipelined Wishbone slave to AXI4-Lite master bridge
//
// One transaction in flight. A response timeout answers the WB side with an
// error when the AXI slave hangs; the AXI transaction is still drained.
//
// Ports:
//   i_clk, i_axi_reset_n           clock, asynchronous active-low reset
//   i_wb_cyc/stb/we/addr/data/sel  WB request (word address)
//   o_wb_stall/ack/err/data        WB response
//   o_axi_aw*, o_axi_w*, *_b*      AXI-lite write channels
//   o_axi_ar*, *_r*                AXI-lite read channels
module wbsp_to_axil
    import wb2axil_pkg::*;
#(
    parameter int         C_AXI_DATA_WIDTH = 32,
    parameter int         C_AXI_ADDR_WIDTH = 28,
    parameter logic [7:0] TIMEOUT_CYCLES   = 8'd10,
    localparam int        DW      = C_AXI_DATA_WIDTH,
    localparam int        AXILLSB = $clog2(C_AXI_DATA_WIDTH/8),
    localparam int        AW      = C_AXI_ADDR_WIDTH - AXILLSB
) (
    input  logic                        i_clk,
    input  logic                        i_axi_reset_n,
    input  logic                        i_wb_cyc,
    input  logic                        i_wb_stb,
    input  logic                        i_wb_we,
    input  logic [AW-1:0]               i_wb_addr,
    input  logic [DW-1:0]               i_wb_data,
    input  logic [DW/8-1:0]             i_wb_sel,
    output logic                        o_wb_stall,
    output logic                        o_wb_ack,
    output logic                        o_wb_err,
    output logic [DW-1:0]               o_wb_data,
    output logic                        o_axi_awvalid,
    input  logic                        i_axi_awready,
    output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_awaddr,
    output logic [2:0]                  o_axi_awprot,
    output logic                        o_axi_wvalid,
    input  logic                        i_axi_wready,
    output logic [DW-1:0]               o_axi_wdata,
    output logic [DW/8-1:0]             o_axi_wstrb,
    input  logic                        i_axi_bvalid,
    output logic                        o_axi_bready,
    input  logic [1:0]                  i_axi_bresp,
    output logic                        o_axi_arvalid,
    input  logic                        i_axi_arready,
    output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_araddr,
    output logic [2:0]                  o_axi_arprot,
    input  logic                        i_axi_rvalid,
    output logic                        o_axi_rready,
    input  logic [DW-1:0]               i_axi_rdata,
    input  logic [1:0]                  i_axi_rresp
);

    state_t                      state, state_nxt;
    logic                        aw_done, w_done, answered;
    logic [7:0]                  timer, timer_nxt;
    logic [C_AXI_ADDR_WIDTH-1:0] addr_q;

    logic accept, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic resp_valid, resp_err, timeout_hit, still_live;
    logic ack_nxt, err_nxt, answer_evt;

    assign aw_hs = o_axi_awvalid && i_axi_awready;
    assign w_hs  = o_axi_wvalid  && i_axi_wready;
    assign ar_hs = o_axi_arvalid && i_axi_arready;
    assign b_hs  = (state == BRESP) && i_axi_bvalid;
    assign r_hs  = (state == RRESP) && i_axi_rvalid;

    // No new request while the previous response pulse is still on the bus.
    assign accept = (state == IDLE) && !o_wb_ack && !o_wb_err && i_wb_cyc && i_wb_stb;

    assign timer_nxt   = (timer == 8'hFF) ? timer : timer + 8'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 8'd0) && (state != IDLE)
                      && (timer != TIMEOUT_CYCLES) && (timer_nxt == TIMEOUT_CYCLES);

    assign resp_valid = b_hs || r_hs;
    assign resp_err   = resp_is_err(b_hs ? i_axi_bresp : i_axi_rresp);
    assign still_live = !answered && i_wb_cyc;

    // A real AXI response in the same cycle as the timeout takes precedence.
    assign ack_nxt    = still_live && resp_valid && !resp_err;
    assign err_nxt    = still_live && (resp_valid ? resp_err : timeout_hit);
    assign answer_evt = ack_nxt || err_nxt || (!i_wb_cyc && (state != IDLE));

    assign o_axi_awaddr = addr_q;
    assign o_axi_araddr = addr_q;
    assign o_axi_awprot = AXPROT_DEFAULT;
    assign o_axi_arprot = AXPROT_DEFAULT;

    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        o_axi_bready = 1'b0;
        o_axi_rready = 1'b0;
        // Stall covers the response cycle so the next accept comes after it.
        o_wb_stall   = (state != IDLE) || o_wb_ack || o_wb_err;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = i_wb_we ? WRITE : READ;
                end
            end
            WRITE: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = BRESP;
                end
            end
            BRESP: begin
                o_axi_bready = 1'b1;
                if (i_axi_bvalid) begin
                    state_nxt = IDLE;
                end
            end
            READ: begin
                if (ar_hs) begin
                    state_nxt = RRESP;
                end
            end
            RRESP: begin
                o_axi_rready = 1'b1;
                if (i_axi_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            o_axi_awvalid <= 1'b0;
            o_axi_wvalid  <= 1'b0;
            o_axi_arvalid <= 1'b0;
            o_axi_wdata   <= '0;
            o_axi_wstrb   <= '0;
            addr_q        <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            answered      <= 1'b0;
            timer         <= 8'd0;
            o_wb_ack      <= 1'b0;
            o_wb_err      <= 1'b0;
            o_wb_data     <= '0;
        end else begin
            o_wb_ack <= ack_nxt;
            o_wb_err <= err_nxt;
            timer    <= (state == IDLE) ? 8'd0 : timer_nxt;

            if (accept) begin
                addr_q        <= {i_wb_addr, {AXILLSB{1'b0}}};
                o_axi_wdata   <= i_wb_data;
                o_axi_wstrb   <= i_wb_sel;
                o_axi_awvalid <= i_wb_we;
                o_axi_wvalid  <= i_wb_we;
                o_axi_arvalid <= !i_wb_we;
                aw_done       <= 1'b0;
                w_done        <= 1'b0;
                answered      <= 1'b0;
            end else begin
                if (aw_hs) begin
                    o_axi_awvalid <= 1'b0;
                    aw_done       <= 1'b1;
                end
                if (w_hs) begin
                    o_axi_wvalid <= 1'b0;
                    w_done       <= 1'b1;
                end
                if (ar_hs) begin
                    o_axi_arvalid <= 1'b0;
                end
                if (answer_evt) begin
                    answered <= 1'b1;
                end
            end

            if (r_hs) begin
                o_wb_data <= i_axi_rdata;
            end
        end
    end

endmodule

// File: tb/tb_wbsp_to_axil.sv
// tb/tb_wbsp_to_axil.sv - self-checking bench for wbsp_to_axil
module tb_wbsp_to_axil;

    logic        clk = 1'b0;
    logic        i_axi_reset_n;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [25:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_stall, o_wb_ack, o_wb_err;
    logic [31:0] o_wb_data;
    logic        o_axi_awvalid, i_axi_awready;
    logic [27:0] o_axi_awaddr;
    logic [2:0]  o_axi_awprot;
    logic        o_axi_wvalid, i_axi_wready;
    logic [31:0] o_axi_wdata;
    logic [3:0]  o_axi_wstrb;
    logic        i_axi_bvalid, o_axi_bready;
    logic [1:0]  i_axi_bresp;
    logic        o_axi_arvalid, i_axi_arready;
    logic [27:0] o_axi_araddr;
    logic [2:0]  o_axi_arprot;
    logic        i_axi_rvalid, o_axi_rready;
    logic [31:0] i_axi_rdata;
    logic [1:0]  i_axi_rresp;

    wbsp_to_axil #(
        .C_AXI_DATA_WIDTH(32),
        .C_AXI_ADDR_WIDTH(28),
        .TIMEOUT_CYCLES(8'd10)
    ) dut (
        .i_clk(clk), .i_axi_reset_n(i_axi_reset_n),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .o_wb_data(o_wb_data),
        .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awprot(o_axi_awprot),
        .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
        .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
        .i_axi_bresp(i_axi_bresp),
        .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
        .o_axi_araddr(o_axi_araddr), .o_axi_arprot(o_axi_arprot),
        .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready),
        .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp)
    );

    always #5 clk = ~clk;

    int cyc_count = 0;
    always @(posedge clk) cyc_count <= cyc_count + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave behaviour knobs, set per transaction.
    int         s_a_d = 0, s_w_d = 0, s_r_d = 0;
    logic [1:0] s_resp  = 2'b00;
    logic [31:0] s_rdata = 32'h0;

    // Slave model state and captures.
    bit aw_pend, w_pend, ar_pend, aw_done, w_done, b_owed, r_owed, b_fire, r_fire;
    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    int r_hs_cnt = 0;
    logic [30:0] cap_aw, cap_ar;
    logic [35:0] cap_w;

    initial begin
        i_axi_awready = 0; i_axi_wready = 0; i_axi_arready = 0;
        i_axi_bvalid = 0; i_axi_rvalid = 0; i_axi_bresp = 0; i_axi_rresp = 0;
        i_axi_rdata = 0;
    end

    // AXI-lite slave: drives on the falling edge; a ready/valid driven here
    // together with the DUT's valid/ready means a handshake at the next rise.
    always @(negedge clk) begin
        if (!i_axi_reset_n) begin
            aw_pend = 0; w_pend = 0; ar_pend = 0; aw_done = 0; w_done = 0;
            b_owed = 0; r_owed = 0; b_fire = 0; r_fire = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
            i_axi_awready = 0; i_axi_wready = 0; i_axi_arready = 0;
            i_axi_bvalid = 0; i_axi_rvalid = 0;
        end else begin
            if (aw_pend) begin aw_done = 1; aw_pend = 0; end
            if (w_pend)  begin w_done = 1;  w_pend = 0;  end
            if (ar_pend) begin ar_pend = 0; r_owed = 1; r_wait = 0; end
            if (aw_done && w_done) begin aw_done = 0; w_done = 0; b_owed = 1; b_wait = 0; end

            if (b_fire) begin i_axi_bvalid = 0; b_fire = 0; end
            if (b_owed) begin
                if (b_wait >= s_r_d) begin
                    i_axi_bvalid = 1; i_axi_bresp = s_resp;
                    if (o_axi_bready) begin b_fire = 1; b_owed = 0; end
                end else b_wait++;
            end

            if (r_fire) begin i_axi_rvalid = 0; r_fire = 0; r_hs_cnt++; end
            if (r_owed) begin
                if (r_wait >= s_r_d) begin
                    i_axi_rvalid = 1; i_axi_rresp = s_resp; i_axi_rdata = s_rdata;
                    if (o_axi_rready) begin r_fire = 1; r_owed = 0; end
                end else r_wait++;
            end

            if (o_axi_awvalid) begin
                if (aw_wait >= s_a_d) begin
                    i_axi_awready = 1; aw_pend = 1; cap_aw = {o_axi_awprot, o_axi_awaddr};
                end else begin i_axi_awready = 0; aw_wait++; end
            end else begin i_axi_awready = 0; aw_wait = 0; end

            if (o_axi_wvalid) begin
                if (w_wait >= s_w_d) begin
                    i_axi_wready = 1; w_pend = 1; cap_w = {o_axi_wstrb, o_axi_wdata};
                end else begin i_axi_wready = 0; w_wait++; end
            end else begin i_axi_wready = 0; w_wait = 0; end

            if (o_axi_arvalid) begin
                if (ar_wait >= s_a_d) begin
                    i_axi_arready = 1; ar_pend = 1; cap_ar = {o_axi_arprot, o_axi_araddr};
                end else begin i_axi_arready = 0; ar_wait++; end
            end else begin i_axi_arready = 0; ar_wait = 0; end
        end
    end

    typedef struct {
        logic        we;
        logic [25:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          a_d, w_d, r_d;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [27:0] exp_axaddr;
        int          exp_acks, exp_errs, exp_lat, exp_done, exp_gap;
    } vec_t;

    vec_t vecs[9];

    task automatic set_slave(input vec_t v);
        s_a_d = v.a_d; s_w_d = v.w_d; s_r_d = v.r_d; s_resp = v.resp; s_rdata = v.rdata;
    endtask

    // Called on a falling edge; returns on the falling edge where stall is low again.
    task automatic run_txn(input vec_t v, output int acc, output int first, output int done,
                           output int acks, output int errs, output logic [31:0] rdat);
        int t;
        set_slave(v);
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = v.we;
        i_wb_addr = v.addr; i_wb_data = v.data; i_wb_sel = v.sel;
        t = 0;
        while (o_wb_stall && t < 40) begin @(negedge clk); t++; end
        check("accept_bound", 64'(t >= 40), 0);
        @(posedge clk); #1;
        acc = cyc_count;
        @(negedge clk);
        i_wb_stb = 0;
        first = -1; acks = 0; errs = 0; rdat = '0; t = 0;
        while (t < 100) begin
            if (o_wb_ack) begin acks++; rdat = o_wb_data; if (first < 0) first = cyc_count; end
            if (o_wb_err) begin errs++; if (first < 0) first = cyc_count; end
            if (!o_wb_stall) break;
            @(negedge clk);
            t++;
        end
        check("response_bound", 64'(t >= 100), 0);
        done = cyc_count - acc;
    endtask

    initial begin
        int acc, first, done, acks, errs, prev_acc, r0;
        logic [31:0] rdat;
        vec_t v;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, first, done, acks, errs, prev_acc, r0;
        logic [31:0] rdat;
        vec_t v;

        //          we  addr          data          sel   a  w  r   resp   rdata         axaddr        ack err lat done gap
        vecs[0] = '{1, 26'h10,       32'hDEADBEEF, 4'hF, 3, 0, 0,  2'b00, 32'h0,        28'h40,       1, 0, 5,  6,  0};
        vecs[1] = '{0, 26'h3,        32'h0,        4'hF, 0, 0, 0,  2'b00, 32'h12345678, 28'h0C,       1, 0, 2,  3,  0};
        vecs[2] = '{0, 26'h3,        32'h0,        4'hF, 0, 0, 0,  2'b10, 32'hCAFEF00D, 28'h0C,       0, 1, 2,  3,  4};
        vecs[3] = '{1, 26'h5,        32'h11223344, 4'h3, 0, 2, 1,  2'b11, 32'h0,        28'h14,       0, 1, 5,  6,  4};
        vecs[4] = '{1, 26'h20,       32'h0BADF00D, 4'hF, 0, 0, 18, 2'b00, 32'h0,        28'h80,       0, 1, 10, 20, 7};
        vecs[5] = '{1, 26'h100,      32'hA5A5A5A5, 4'hF, 0, 0, 0,  2'b00, 32'h0,        28'h400,      1, 0, 2,  3,  21};
        vecs[6] = '{1, 26'h101,      32'h5A5A5A5A, 4'hF, 0, 0, 0,  2'b00, 32'h0,        28'h404,      1, 0, 2,  3,  4};
        vecs[7] = '{0, 26'h100,      32'h0,        4'hF, 0, 0, 0,  2'b00, 32'h0F1E2D3C, 28'h400,      1, 0, 2,  3,  4};
        vecs[8] = '{0, 26'h3FFFFFF,  32'h0,        4'hF, 2, 0, 1,  2'b01, 32'hFFFFFFFF, 28'hFFFFFFC,  1, 0, 5,  6,  4};

        i_axi_reset_n = 0;
        i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_addr = 0; i_wb_data = 0; i_wb_sel = 0;
        repeat (3) @(negedge clk);
        check("reset_ctrl_outputs",
              {56'd0, o_wb_stall, o_wb_ack, o_wb_err, o_axi_awvalid, o_axi_wvalid,
               o_axi_arvalid, o_axi_bready, o_axi_rready}, 0);
        check("reset_wb_data", {32'd0, o_wb_data}, 0);
        i_axi_reset_n = 1;
        @(negedge clk);

        prev_acc = 0;
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            run_txn(v, acc, first, done, acks, errs, rdat);
            check($sformatf("v%0d_axaddr", i), {33'd0, v.we ? cap_aw : cap_ar}, {33'd0, 3'b000, v.exp_axaddr});
            check($sformatf("v%0d_acks", i), 64'(acks), 64'(v.exp_acks));
            check($sformatf("v%0d_errs", i), 64'(errs), 64'(v.exp_errs));
            check($sformatf("v%0d_latency", i), 64'(first - acc), 64'(v.exp_lat));
            check($sformatf("v%0d_stall_release", i), 64'(done), 64'(v.exp_done));
            if (v.we)
                check($sformatf("v%0d_wstrb_wdata", i), {28'd0, cap_w}, {28'd0, v.sel, v.data});
            else if (v.exp_acks > 0)
                check($sformatf("v%0d_rdata", i), {32'd0, rdat}, {32'd0, v.rdata});
            if (v.exp_gap != 0)
                check($sformatf("v%0d_accept_gap", i), 64'(acc - prev_acc), 64'(v.exp_gap));
            prev_acc = acc;
        end

        // Abandoned read: cyc drops two cycles in, rvalid arrives at cycle 5.
        v = '{0, 26'h7, 32'h0, 4'hF, 0, 0, 3, 2'b00, 32'h77777777, 28'h1C, 0, 0, 0, 0, 0};
        set_slave(v);
        r0 = r_hs_cnt;
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = v.addr;
        @(posedge clk); #1;
        acc = cyc_count;
        @(negedge clk); i_wb_stb = 0;
        @(negedge clk);
        @(negedge clk); i_wb_cyc = 0;
        acks = 0; errs = 0;
        for (int t = 0; t < 30; t++) begin
            if (o_wb_ack) acks++;
            if (o_wb_err) errs++;
            if (!o_wb_stall) break;
            @(negedge clk);
        end
        done = cyc_count - acc;
        @(posedge clk); #1;
        check("drop_acks", 64'(acks), 0);
        check("drop_errs", 64'(errs), 0);
        check("drop_idle_cycle", 64'(done), 5);
        check("drop_r_handshake", 64'(r_hs_cnt - r0), 1);
        @(negedge clk);
        v = '{0, 26'h8, 32'h0, 4'hF, 0, 0, 0, 2'b00, 32'h13572468, 28'h20, 1, 0, 2, 3, 0};
        run_txn(v, acc, first, done, acks, errs, rdat);
        check("after_drop_acks", 64'(acks), 1);
        check("after_drop_latency", 64'(first - acc), 2);
        check("after_drop_rdata", {32'd0, rdat}, {32'd0, 32'h13572468});

        // Reset while a write waits for awready.
        @(negedge clk);
        v = '{1, 26'h30, 32'h01020304, 4'hF, 5, 0, 0, 2'b00, 32'h0, 28'hC0, 0, 0, 0, 0, 0};
        set_slave(v);
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_addr = v.addr; i_wb_data = v.data; i_wb_sel = v.sel;
        @(posedge clk); #1;
        @(negedge clk); i_wb_stb = 0;
        @(negedge clk);
        check("rst_pre_awvalid", {63'd0, o_axi_awvalid}, 1);
        #2;
        i_axi_reset_n = 0; i_wb_cyc = 0;
        #1;
        check("rst_async_ctrl",
              {56'd0, o_wb_stall, o_wb_ack, o_wb_err, o_axi_awvalid, o_axi_wvalid,
               o_axi_arvalid, o_axi_bready, o_axi_rready}, 0);
        check("rst_async_wb_data", {32'd0, o_wb_data}, 0);
        repeat (2) @(negedge clk);
        i_axi_reset_n = 1;
        @(negedge clk);
        check("rst_release_stall", {63'd0, o_wb_stall}, 0);
        v = '{1, 26'h33, 32'h600DCAFE, 4'hC, 0, 0, 0, 2'b00, 32'h0, 28'hCC, 1, 0, 2, 3, 0};
        run_txn(v, acc, first, done, acks, errs, rdat);
        check("post_rst_awaddr", {33'd0, cap_aw}, {33'd0, 3'b000, 28'hCC});
        check("post_rst_wdata", {28'd0, cap_w}, {28'd0, 4'hC, 32'h600DCAFE});
        check("post_rst_acks", 64'(acks), 1);
        check("post_rst_latency", 64'(first - acc), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
